// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use detection across issue slots, divider stall FSM,
// stage enable/flush priority resolution and a saturating D-stall cycle counter.

module hazard_slot_cmp #(
    parameter int NUM_SLOTS = 2,
    parameter int REG_AW    = 5
) (
    input  logic                                d_valid,
    input  logic [REG_AW-1:0]                   d_rs,
    input  logic [REG_AW-1:0]                   d_rt,
    input  logic [NUM_SLOTS-1:0]                e_load,
    input  logic [NUM_SLOTS-1:0][REG_AW-1:0]    e_waddr,
    input  logic [NUM_SLOTS-1:0]                m_load,
    input  logic [NUM_SLOTS-1:0][REG_AW-1:0]    m_waddr,
    output logic                                hit
);
    // $zero is hardwired, so a load targeting it never creates a dependency
    always_comb begin
        hit = 1'b0;
        for (int j = 0; j < NUM_SLOTS; j++) begin
            if (e_load[j] && e_waddr[j] != '0 && (d_rs == e_waddr[j] || d_rt == e_waddr[j]))
                hit = 1'b1;
            if (m_load[j] && m_waddr[j] != '0 && (d_rs == m_waddr[j] || d_rt == m_waddr[j]))
                hit = 1'b1;
        end
        hit = hit & d_valid;
    end
endmodule

module hazard_ctrl #(
    parameter int NUM_SLOTS  = 2,
    parameter int REG_AW     = 5,
    parameter int DIV_CYCLES = 8,
    parameter int CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SLOTS-1:0]          D_valid,
    input  logic [NUM_SLOTS*REG_AW-1:0]   D_rs,
    input  logic [NUM_SLOTS*REG_AW-1:0]   D_rt,
    input  logic [NUM_SLOTS-1:0]          E_memtoReg,
    input  logic [NUM_SLOTS*REG_AW-1:0]   E_reg_waddr,
    input  logic [NUM_SLOTS-1:0]          M_memtoReg,
    input  logic [NUM_SLOTS*REG_AW-1:0]   M_reg_waddr,
    input  logic                          E_branch_taken,
    input  logic                          E_div_start,
    input  logic                          M_exception,
    input  logic                          fifo_full,
    input  logic                          perf_clr,
    output logic                          F_ena,
    output logic                          D_ena,
    output logic                          E_ena,
    output logic                          M_ena,
    output logic                          W_ena,
    output logic                          F_flush,
    output logic                          D_flush,
    output logic                          E_flush,
    output logic                          M_flush,
    output logic                          W_flush,
    output logic                          div_busy,
    output logic                          div_done,
    output logic [CNT_W-1:0]              stall_cnt
);
    localparam int DW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    logic [NUM_SLOTS-1:0][REG_AW-1:0] d_rs_a, d_rt_a, e_waddr_a, m_waddr_a;
    logic [NUM_SLOTS-1:0]             slot_hit;
    logic                             lw_hit, div_stall;
    state_t                           state, state_nxt;
    logic [DW-1:0]                    div_cnt, div_cnt_nxt;

    assign d_rs_a    = D_rs;
    assign d_rt_a    = D_rt;
    assign e_waddr_a = E_reg_waddr;
    assign m_waddr_a = M_reg_waddr;

    generate
        for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
            hazard_slot_cmp #(.NUM_SLOTS(NUM_SLOTS), .REG_AW(REG_AW)) u_cmp (
                .d_valid (D_valid[i]),
                .d_rs    (d_rs_a[i]),
                .d_rt    (d_rt_a[i]),
                .e_load  (E_memtoReg),
                .e_waddr (e_waddr_a),
                .m_load  (M_memtoReg),
                .m_waddr (m_waddr_a),
                .hit     (slot_hit[i])
            );
        end
    endgenerate

    assign lw_hit    = |slot_hit;
    assign div_stall = (state == IDLE && E_div_start) || (state == BUSY && div_cnt != '0);

    always_comb begin
        state_nxt   = state;
        div_cnt_nxt = div_cnt;
        if (M_exception) begin
            state_nxt   = IDLE;
            div_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: if (E_div_start) begin
                    state_nxt   = BUSY;
                    div_cnt_nxt = DW'(DIV_CYCLES - 1);
                end
                BUSY: if (div_cnt != '0) div_cnt_nxt = div_cnt - DW'(1);
                      else               state_nxt   = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            div_cnt <= '0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_cnt_nxt;
        end
    end

    always_comb begin
        {F_ena, D_ena, E_ena, M_ena, W_ena}           = '1;
        {F_flush, D_flush, E_flush, M_flush, W_flush} = '0;
        div_busy = 1'b0;
        div_done = 1'b0;
        if (rst) begin
            {F_flush, D_flush, E_flush, M_flush, W_flush} = '1;
        end else begin
            div_busy = (state == BUSY);
            div_done = (state == BUSY) && div_cnt == '0;
            if (M_exception) begin
                {F_flush, D_flush, E_flush, M_flush} = '1;
            end else begin
                // a taken branch under a divide stall simply waits in E
                if (div_stall)
                    {F_ena, D_ena, E_ena, M_ena} = '0;
                else if (E_branch_taken)
                    {D_flush, E_flush} = '1;
                else if (lw_hit) begin
                    {F_ena, D_ena} = '0;
                    E_flush        = 1'b1;
                end
                if (fifo_full) F_ena = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || perf_clr)
            stall_cnt <= '0;
        else if (!D_ena && !(&stall_cnt))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboarded random + directed bench for hazard_ctrl against a behavioural model.

module tb_hazard_ctrl;
    localparam int NS = 2, AW = 5, DC = 8, CW = 4;

    logic               clk = 1'b0, rst = 1'b1;
    logic [NS-1:0]      D_valid = '0, E_memtoReg = '0, M_memtoReg = '0;
    logic [NS*AW-1:0]   D_rs = '0, D_rt = '0, E_reg_waddr = '0, M_reg_waddr = '0;
    logic               E_branch_taken = 0, E_div_start = 0, M_exception = 0, fifo_full = 0, perf_clr = 0;
    logic               F_ena, D_ena, E_ena, M_ena, W_ena;
    logic               F_flush, D_flush, E_flush, M_flush, W_flush;
    logic               div_busy, div_done;
    logic [CW-1:0]      stall_cnt;

    hazard_ctrl #(.NUM_SLOTS(NS), .REG_AW(AW), .DIV_CYCLES(DC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .D_valid(D_valid), .D_rs(D_rs), .D_rt(D_rt),
        .E_memtoReg(E_memtoReg), .E_reg_waddr(E_reg_waddr),
        .M_memtoReg(M_memtoReg), .M_reg_waddr(M_reg_waddr),
        .E_branch_taken(E_branch_taken), .E_div_start(E_div_start), .M_exception(M_exception),
        .fifo_full(fifo_full), .perf_clr(perf_clr),
        .F_ena(F_ena), .D_ena(D_ena), .E_ena(E_ena), .M_ena(M_ena), .W_ena(W_ena),
        .F_flush(F_flush), .D_flush(D_flush), .E_flush(E_flush), .M_flush(M_flush), .W_flush(W_flush),
        .div_busy(div_busy), .div_done(div_done), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0]   ctl;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0, failures = 0;

    // model: divide progress is "cycles elapsed since start"; stall counter as plain int
    bit m_div;
    int m_elapsed = 0;
    int m_cnt = 0;

    function automatic bit lw_model();
        bit h = 0;
        for (int i = 0; i < NS; i++) begin
            int rs = int'(D_rs[i*AW +: AW]);
            int rt = int'(D_rt[i*AW +: AW]);
            for (int j = 0; j < NS; j++) begin
                int ea = int'(E_reg_waddr[j*AW +: AW]);
                int ma = int'(M_reg_waddr[j*AW +: AW]);
                if (D_valid[i] && E_memtoReg[j] && ea != 0 && (rs == ea || rt == ea)) h = 1;
                if (D_valid[i] && M_memtoReg[j] && ma != 0 && (rs == ma || rt == ma)) h = 1;
            end
        end
        return h;
    endfunction

    task automatic tick();
        bit   fe = 1, de = 1, ee = 1, me = 1, we = 1;
        bit   ff = 0, df = 0, ef = 0, mf = 0, wf = 0;
        bit   busy = 0, done = 0;
        bit   stall;
        exp_t e;
        stall = (!m_div && E_div_start) || (m_div && m_elapsed < DC);
        if (rst) begin
            {ff, df, ef, mf, wf} = 5'b11111;
        end else begin
            busy = m_div;
            done = m_div && m_elapsed == DC;
            if (M_exception) {ff, df, ef, mf} = 4'b1111;
            else begin
                if (stall) {fe, de, ee, me} = 4'b0000;
                else if (E_branch_taken) {df, ef} = 2'b11;
                else if (lw_model()) begin fe = 0; de = 0; ef = 1; end
                if (fifo_full) fe = 0;
            end
        end
        e.ctl = {fe, de, ee, me, we, ff, df, ef, mf, wf, busy, done};
        e.cnt = CW'(m_cnt);
        q.push_back(e);
        if (rst) begin
            m_div = 0; m_elapsed = 0; m_cnt = 0;
        end else begin
            if (perf_clr) m_cnt = 0;
            else if (!de && m_cnt < (1 << CW) - 1) m_cnt++;
            if (M_exception) m_div = 0;
            else if (!m_div && E_div_start) begin m_div = 1; m_elapsed = 1; end
            else if (m_div) begin
                if (m_elapsed < DC) m_elapsed++;
                else m_div = 0;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_in();
        rst = 0; D_valid = '0; D_rs = '0; D_rt = '0; E_memtoReg = '0; M_memtoReg = '0;
        E_reg_waddr = '0; M_reg_waddr = '0; E_branch_taken = 0; E_div_start = 0;
        M_exception = 0; fifo_full = 0; perf_clr = 0;
    endtask

    task automatic load_use_in();
        idle_in();
        D_valid = 2'b10; D_rs[AW +: AW] = 5'd5;
        E_memtoReg = 2'b01; E_reg_waddr[0 +: AW] = 5'd5;
    endtask

    initial begin
        exp_t e;
        logic [11:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {F_ena, D_ena, E_ena, M_ena, W_ena, F_flush, D_flush, E_flush,
                       M_flush, W_flush, div_busy, div_done};
                checks++;
                if (act !== e.ctl) begin
                    failures++;
                    $display("FAIL ctl t=%0t got=%b expected=%b", $time, act, e.ctl);
                end
                checks++;
                if (stall_cnt !== e.cnt) begin
                    failures++;
                    $display("FAIL stall_cnt t=%0t got=%0d expected=%0d", $time, stall_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk); #1;
        tick(); tick();
        idle_in(); tick();
        load_use_in(); tick();
        idle_in(); tick();
        D_valid = 2'b01; E_memtoReg = 2'b01; tick();
        idle_in(); E_div_start = 1; repeat (9) tick();
        idle_in(); tick(); tick();
        load_use_in(); E_branch_taken = 1; tick();
        idle_in(); E_div_start = 1; repeat (3) tick();
        M_exception = 1; tick();
        idle_in(); repeat (3) tick();
        E_div_start = 1; repeat (3) tick();
        rst = 1; tick();
        idle_in(); repeat (2) tick();
        load_use_in(); repeat (20) tick();
        perf_clr = 1; tick();
        idle_in(); tick();
        for (int n = 0; n < 2500; n++) begin
            rst            = ($urandom_range(0, 199) == 0);
            perf_clr       = ($urandom_range(0, 49) == 0);
            M_exception    = ($urandom_range(0, 39) == 0);
            E_branch_taken = ($urandom_range(0, 7) == 0);
            E_div_start    = ($urandom_range(0, 9) == 0);
            fifo_full      = ($urandom_range(0, 3) == 0);
            D_valid        = NS'($urandom);
            E_memtoReg     = NS'($urandom);
            M_memtoReg     = NS'($urandom);
            for (int s = 0; s < NS; s++) begin
                D_rs[s*AW +: AW]        = AW'($urandom_range(0, 3));
                D_rt[s*AW +: AW]        = AW'($urandom_range(0, 3));
                E_reg_waddr[s*AW +: AW] = AW'($urandom_range(0, 3));
                M_reg_waddr[s*AW +: AW] = AW'($urandom_range(0, 3));
            end
            tick();
        end
        idle_in(); tick();
        repeat (4) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
